// File: rtl/dual_issue_stage_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dual_issue_stage_if
// Description : Bus between the dual-slot decoder, the issue stage and the
//               two execution lanes. Arrays are [1:0], one entry per slot;
//               index 0 is the older instruction.
//                 in_*  : decoded pair plus ready/valid handshake upstream
//                 out_* : registered per-lane presentation plus out_ready
//               master : environment side (decoder + lanes)
//               slave  : the issue stage
// Revision    : 1.0 - initial release
// ============================================================================
interface dual_issue_stage_if #(
    parameter int WIDTH = 32,
    parameter int RS    = 5,
    parameter int RD    = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            in_slot_valid;
    logic [1:0][4:0]       in_op_code;
    logic [1:0][3:0]       in_sub_op_code;
    logic [1:0][RS-1:0]    in_rs1;
    logic [1:0][RS-1:0]    in_rs2;
    logic [1:0][RD-1:0]    in_rd;
    logic [1:0][WIDTH-1:0] in_imm;
    logic [1:0][4:0]       in_shift_size;
    logic [WIDTH-1:0]      in_pc;

    logic                  out_ready;
    logic [1:0]            out_valid;
    logic [1:0][4:0]       out_op_code;
    logic [1:0][3:0]       out_sub_op_code;
    logic [1:0][RS-1:0]    out_rs1;
    logic [1:0][RS-1:0]    out_rs2;
    logic [1:0][RD-1:0]    out_rd;
    logic [1:0][WIDTH-1:0] out_imm;
    logic [1:0][4:0]       out_shift_size;
    logic [1:0][WIDTH-1:0] out_pc;

    modport master (
        output in_valid, in_slot_valid, in_op_code, in_sub_op_code,
               in_rs1, in_rs2, in_rd, in_imm, in_shift_size, in_pc,
               out_ready,
        input  in_ready, out_valid, out_op_code, out_sub_op_code,
               out_rs1, out_rs2, out_rd, out_imm, out_shift_size, out_pc
    );

    modport slave (
        input  in_valid, in_slot_valid, in_op_code, in_sub_op_code,
               in_rs1, in_rs2, in_rd, in_imm, in_shift_size, in_pc,
               out_ready,
        output in_ready, out_valid, out_op_code, out_sub_op_code,
               out_rs1, out_rs2, out_rd, out_imm, out_shift_size, out_pc
    );
endinterface
`default_nettype wire

// File: rtl/dual_issue_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dual_issue_stage
// Description : Registers one decoded instruction pair per cycle and checks
//               it for intra-pair hazards (RAW, WAW, two memory ops, control
//               op in slot 0). Clean pairs issue to both lanes together;
//               conflicting pairs issue slot 0 first, then slot 1.
// Ports       : clk   - clock
//               rst_n - synchronous reset, active low
//               flush - synchronous kill of held and incoming instructions
//               bus   - dual_issue_stage_if.slave (upstream pair + lanes)
// Revision    : 1.0 - initial release
// ============================================================================
module dual_issue_stage #(
    parameter int WIDTH = 32,
    parameter int RS    = 5,
    parameter int RD    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    dual_issue_stage_if.slave bus
);
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    // Common width so source and destination indices compare cleanly even
    // if RS and RD ever differ.
    localparam int IDXW = (RS > RD) ? RS : RD;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_SECOND = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  split_q;
    logic [1:0]            slot_v_q;
    logic [1:0][4:0]       op_q;
    logic [1:0][3:0]       sub_op_q;
    logic [1:0][RS-1:0]    rs1_q;
    logic [1:0][RS-1:0]    rs2_q;
    logic [1:0][RD-1:0]    rd_q;
    logic [1:0][WIDTH-1:0] imm_q;
    logic [1:0][4:0]       shamt_q;
    logic [1:0][WIDTH-1:0] pc_q;

    logic                  accept;
    logic                  load_pair;
    logic                  pair_split;
    logic                  rd0_nz;
    logic                  raw_hz;
    logic                  waw_hz;
    logic                  lsu_hz;
    logic                  ctrl_hz;
    logic [IDXW-1:0]       rd0_x;
    logic [IDXW-1:0]       rd1_x;
    logic [IDXW-1:0]       rs1_1_x;
    logic [IDXW-1:0]       rs2_1_x;

    function automatic logic is_mem(input logic [4:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    function automatic logic is_ctrl(input logic [4:0] op);
        return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

    // ------------------------------------------------------------------
    // Intra-pair hazard detection on the incoming pair
    // ------------------------------------------------------------------
    assign rd0_x   = IDXW'(bus.in_rd[0]);
    assign rd1_x   = IDXW'(bus.in_rd[1]);
    assign rs1_1_x = IDXW'(bus.in_rs1[1]);
    assign rs2_1_x = IDXW'(bus.in_rs2[1]);

    // x0 is never a real dependency: rd=0 means "no write".
    assign rd0_nz  = (rd0_x != '0);
    assign raw_hz  = rd0_nz && ((rs1_1_x == rd0_x) || (rs2_1_x == rd0_x));
    assign waw_hz  = rd0_nz && (rd1_x == rd0_x);
    assign lsu_hz  = is_mem(bus.in_op_code[0]) && is_mem(bus.in_op_code[1]);
    assign ctrl_hz = is_ctrl(bus.in_op_code[0]);

    assign pair_split = (bus.in_slot_valid == 2'b11) &&
                        (raw_hz || waw_hz || lsu_hz || ctrl_hz);

    // ------------------------------------------------------------------
    // Handshake: a new pair is taken only when the held one is fully
    // retiring this cycle (or nothing is held). Split pairs block intake
    // while slot 0 waits, which is what creates the single bubble.
    // ------------------------------------------------------------------
    assign bus.in_ready = !flush &&
                          ((state_q == S_IDLE) ||
                           (bus.out_ready && ((state_q == S_SECOND) ||
                                              ((state_q == S_HOLD) && !split_q))));

    assign accept    = bus.in_valid && bus.in_ready;
    // An all-invalid pair is consumed but never presented.
    assign load_pair = accept && (bus.in_slot_valid != 2'b00);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load_pair) begin
                        state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        if (split_q) begin
                            state_d = S_SECOND;
                        end else if (load_pair) begin
                            state_d = S_HOLD;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_SECOND: begin
                    if (bus.out_ready) begin
                        state_d = load_pair ? S_HOLD : S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and payload registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            split_q  <= 1'b0;
            slot_v_q <= '0;
            op_q     <= '0;
            sub_op_q <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            imm_q    <= '0;
            shamt_q  <= '0;
            pc_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                split_q  <= pair_split;
                slot_v_q <= bus.in_slot_valid;
                op_q     <= bus.in_op_code;
                sub_op_q <= bus.in_sub_op_code;
                rs1_q    <= bus.in_rs1;
                rs2_q    <= bus.in_rs2;
                rd_q     <= bus.in_rd;
                imm_q    <= bus.in_imm;
                shamt_q  <= bus.in_shift_size;
                pc_q     <= {bus.in_pc + WIDTH'(4), bus.in_pc};
            end
        end
    end

    // ------------------------------------------------------------------
    // Lane presentation: decoded purely from registers. Slots keep their
    // lane, so a split pair shows slot 0 on lane 0, then slot 1 on lane 1.
    // ------------------------------------------------------------------
    always_comb begin
        bus.out_valid = 2'b00;
        case (state_q)
            S_HOLD:   bus.out_valid = split_q ? 2'b01 : slot_v_q;
            S_SECOND: bus.out_valid = 2'b10;
            default:  bus.out_valid = 2'b00;
        endcase
    end

    assign bus.out_op_code     = op_q;
    assign bus.out_sub_op_code = sub_op_q;
    assign bus.out_rs1         = rs1_q;
    assign bus.out_rs2         = rs2_q;
    assign bus.out_rd          = rd_q;
    assign bus.out_imm         = imm_q;
    assign bus.out_shift_size  = shamt_q;
    assign bus.out_pc          = pc_q;

endmodule
`default_nettype wire
